// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted branches. Each resolve is checked against its stored prediction,
// which drives predictor training, mispredict flush and saturating statistics.
module branch_resolve_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic                     clock,
  input  logic                     rst,
  input  logic                     push,
  input  logic [PC_W-1:0]          push_pc,
  input  logic                     push_pred,
  input  logic                     resolve,
  input  logic                     resolve_taken,
  output logic                     upd_valid,
  output logic                     upd_taken,
  output logic                     mispredict,
  output logic [PC_W-1:0]          mispredict_pc,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow,
  output logic [CNT_W-1:0]         stat_branches,
  output logic [CNT_W-1:0]         stat_mispredicts
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;

  logic [PC_W-1:0]  pc_mem [DEPTH];
  logic             pred_mem [DEPTH];

  logic [PTR_W-1:0] head_reg, head_next;
  logic [PTR_W-1:0] tail_reg, tail_next;
  logic [CW-1:0]    count_reg, count_next;
  logic             upd_valid_reg, upd_taken_reg, mispredict_reg;
  logic [PC_W-1:0]  mispredict_pc_reg;
  logic             full_reg, empty_reg, overflow_reg, underflow_reg;
  logic [CNT_W-1:0] stat_branches_reg, stat_mispredicts_reg;

  logic             resolve_ok, mis, push_ok, full_now, overflow_set, underflow_set;
  logic [PC_W-1:0]  head_pc;
  logic             head_pred;

  always_comb begin
    head_pc       = pc_mem[head_reg];
    head_pred     = pred_mem[head_reg];
    full_now      = (count_reg == CW'(DEPTH));
    resolve_ok    = resolve && (count_reg != '0);
    mis           = resolve_ok && (head_pred != resolve_taken);
    // A full queue still accepts a push when a matching resolve frees the head slot.
    push_ok       = push && !mis && (!full_now || resolve_ok);
    overflow_set  = push && !mis && full_now && !resolve_ok;
    underflow_set = resolve && (count_reg == '0);
    head_next     = head_reg;
    tail_next     = tail_reg;
    count_next    = count_reg;
    if (mis) begin
      // Everything younger than a mispredicted branch is wrong-path.
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
    end else begin
      if (resolve_ok) head_next = head_reg + PTR_W'(1);
      if (push_ok)    tail_next = tail_reg + PTR_W'(1);
      count_next = count_reg + CW'(push_ok) - CW'(resolve_ok);
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) begin
      pc_mem[tail_reg]   <= push_pc;
      pred_mem[tail_reg] <= push_pred;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      head_reg             <= '0;
      tail_reg             <= '0;
      count_reg            <= '0;
      upd_valid_reg        <= 1'b0;
      upd_taken_reg        <= 1'b0;
      mispredict_reg       <= 1'b0;
      mispredict_pc_reg    <= '0;
      full_reg             <= 1'b0;
      empty_reg            <= 1'b1;
      overflow_reg         <= 1'b0;
      underflow_reg        <= 1'b0;
      stat_branches_reg    <= '0;
      stat_mispredicts_reg <= '0;
    end else begin
      head_reg       <= head_next;
      tail_reg       <= tail_next;
      count_reg      <= count_next;
      full_reg       <= (count_next == CW'(DEPTH));
      empty_reg      <= (count_next == '0);
      upd_valid_reg  <= resolve_ok;
      mispredict_reg <= mis;
      if (resolve_ok) upd_taken_reg <= resolve_taken;
      if (mis) mispredict_pc_reg <= head_pc;
      if (overflow_set) overflow_reg <= 1'b1;
      if (underflow_set) underflow_reg <= 1'b1;
      if (resolve_ok && (stat_branches_reg != '1))
        stat_branches_reg <= stat_branches_reg + CNT_W'(1);
      if (mis && (stat_mispredicts_reg != '1))
        stat_mispredicts_reg <= stat_mispredicts_reg + CNT_W'(1);
    end
  end

  assign upd_valid        = upd_valid_reg;
  assign upd_taken        = upd_taken_reg;
  assign mispredict       = mispredict_reg;
  assign mispredict_pc    = mispredict_pc_reg;
  assign full             = full_reg;
  assign empty            = empty_reg;
  assign count            = count_reg;
  assign overflow         = overflow_reg;
  assign underflow        = underflow_reg;
  assign stat_branches    = stat_branches_reg;
  assign stat_mispredicts = stat_mispredicts_reg;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Bench for branch_resolve_queue: hand-derived vector table, then a queue-based reference
// model for wrap-around, statistic saturation and reset while entries are queued.
module tb_branch_resolve_queue;

  localparam int DEPTH = 4;
  localparam int PC_W  = 32;
  localparam int CNT_W = 2;

  logic              clock = 1'b0;
  logic              rst = 1'b1;
  logic              push = 1'b0;
  logic [PC_W-1:0]   push_pc = '0;
  logic              push_pred = 1'b0;
  logic              resolve = 1'b0;
  logic              resolve_taken = 1'b0;
  logic              upd_valid, upd_taken, mispredict;
  logic [PC_W-1:0]   mispredict_pc;
  logic              full, empty, overflow, underflow;
  logic [2:0]        count;
  logic [CNT_W-1:0]  stat_branches, stat_mispredicts;

  branch_resolve_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .rst(rst), .push(push), .push_pc(push_pc), .push_pred(push_pred),
    .resolve(resolve), .resolve_taken(resolve_taken), .upd_valid(upd_valid),
    .upd_taken(upd_taken), .mispredict(mispredict), .mispredict_pc(mispredict_pc),
    .full(full), .empty(empty), .count(count), .overflow(overflow), .underflow(underflow),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        uv, ut, mp;
    logic [31:0] mpc;
    logic [2:0]  cnt;
    logic        ovf, unf;
    logic [1:0]  sb, sm;
  } exp_t;

  typedef struct packed {
    logic        r, p;
    logic [31:0] pc;
    logic        pr, res, tk;
    exp_t        e;
  } vec_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        pred;
  } ent_t;

  int   errors = 0;
  int   checks = 0;
  int   txn = 0;
  exp_t exp_q[$];
  vec_t tbl[27];

  ent_t        mq[$];
  logic        m_ut, m_ovf, m_unf;
  logic [31:0] m_mpc;
  int          m_sb, m_sm;

  function automatic vec_t mk(bit r, bit p, logic [31:0] pc, bit pr, bit res, bit tk,
                              bit uv, bit ut, bit mp, logic [31:0] mpc, int cnt,
                              bit ovf, bit unf, int sb, int sm);
    vec_t v;
    v.r = r; v.p = p; v.pc = pc; v.pr = pr; v.res = res; v.tk = tk;
    v.e.uv = uv; v.e.ut = ut; v.e.mp = mp; v.e.mpc = mpc; v.e.cnt = 3'(cnt);
    v.e.ovf = ovf; v.e.unf = unf; v.e.sb = 2'(sb); v.e.sm = 2'(sm);
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL txn%0d %s: got %h expected %h", txn, name, act, expv);
    end
  endtask

  // Drive one cycle of stimulus, record its expectation, then compare once outputs settle.
  task automatic step(input bit r, input bit p, input logic [31:0] pc, input bit pr,
                      input bit res, input bit tk, input exp_t e);
    exp_t x;
    rst = r; push = p; push_pc = pc; push_pred = pr; resolve = res; resolve_taken = tk;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    x = exp_q.pop_front();
    check("train", {upd_valid, upd_taken}, {x.uv, x.ut});
    check("mispredict", {mispredict, mispredict_pc}, {x.mp, x.mpc});
    check("occupancy", {count, full, empty}, {x.cnt, (x.cnt == 3'd4), (x.cnt == 3'd0)});
    check("sticky", {overflow, underflow}, {x.ovf, x.unf});
    check("stats", {stat_branches, stat_mispredicts}, {x.sb, x.sm});
    $display("txn %0d rst=%0b push=%0b pc=%h res=%0b tk=%0b -> uv=%0b ut=%0b mp=%0b mpc=%h cnt=%0d",
             txn, r, p, pc, res, tk, upd_valid, upd_taken, mispredict, mispredict_pc, count);
    txn++;
  endtask

  task automatic model_reset();
    mq.delete();
    m_ut = 0; m_ovf = 0; m_unf = 0; m_mpc = '0; m_sb = 0; m_sm = 0;
  endtask

  task automatic mstep(input bit r, input bit p, input logic [31:0] pc, input bit pr,
                       input bit res, input bit tk);
    exp_t e;
    ent_t h;
    bit   res_ok, mis;
    e = '0;
    res_ok = 0;
    mis = 0;
    if (r) begin
      model_reset();
    end else begin
      res_ok = res && (mq.size() > 0);
      if (res && !res_ok) m_unf = 1;
      if (res_ok) begin
        h = mq.pop_front();
        m_ut = tk;
        if (m_sb < 3) m_sb++;
        if (h.pred != tk) begin
          mis = 1;
          m_mpc = h.pc;
          if (m_sm < 3) m_sm++;
          mq.delete();
        end
      end
      if (p && !mis) begin
        if (mq.size() < DEPTH) mq.push_back({pc, pr});
        else m_ovf = 1;
      end
    end
    e.uv = res_ok; e.ut = m_ut; e.mp = mis; e.mpc = m_mpc; e.cnt = 3'(mq.size());
    e.ovf = m_ovf; e.unf = m_unf; e.sb = 2'(m_sb); e.sm = 2'(m_sm);
    step(r, p, pc, pr, res, tk, e);
  endtask

  initial begin
    //               r p pc       pr res tk  uv ut mp mpc     cnt ovf unf sb sm
    tbl[0]  = mk(1, 0, 32'h0,   0, 0, 0,  0, 0, 0, 32'h0,   0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 32'h100, 1, 0, 0,  0, 0, 0, 32'h0,   1, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 32'h0,   0, 1, 1,  1, 1, 0, 32'h0,   0, 0, 0, 1, 0);
    tbl[3]  = mk(0, 1, 32'h200, 1, 0, 0,  0, 1, 0, 32'h0,   1, 0, 0, 1, 0);
    tbl[4]  = mk(0, 1, 32'h204, 0, 0, 0,  0, 1, 0, 32'h0,   2, 0, 0, 1, 0);
    tbl[5]  = mk(0, 1, 32'h208, 1, 0, 0,  0, 1, 0, 32'h0,   3, 0, 0, 1, 0);
    tbl[6]  = mk(0, 1, 32'h20c, 1, 0, 0,  0, 1, 0, 32'h0,   4, 0, 0, 1, 0);
    tbl[7]  = mk(0, 1, 32'h210, 0, 0, 0,  0, 1, 0, 32'h0,   4, 1, 0, 1, 0);
    tbl[8]  = mk(0, 1, 32'h214, 0, 1, 1,  1, 1, 0, 32'h0,   4, 1, 0, 2, 0);
    tbl[9]  = mk(0, 0, 32'h0,   0, 1, 0,  1, 0, 0, 32'h0,   3, 1, 0, 3, 0);
    tbl[10] = mk(0, 0, 32'h0,   0, 1, 1,  1, 1, 0, 32'h0,   2, 1, 0, 3, 0);
    tbl[11] = mk(0, 0, 32'h0,   0, 1, 1,  1, 1, 0, 32'h0,   1, 1, 0, 3, 0);
    tbl[12] = mk(0, 1, 32'h300, 1, 1, 1,  1, 1, 1, 32'h214, 0, 1, 0, 3, 1);
    tbl[13] = mk(0, 0, 32'h0,   0, 0, 0,  0, 1, 0, 32'h214, 0, 1, 0, 3, 1);
    tbl[14] = mk(0, 1, 32'h10,  0, 0, 0,  0, 1, 0, 32'h214, 1, 1, 0, 3, 1);
    tbl[15] = mk(0, 1, 32'h20,  1, 0, 0,  0, 1, 0, 32'h214, 2, 1, 0, 3, 1);
    tbl[16] = mk(0, 1, 32'h30,  1, 0, 0,  0, 1, 0, 32'h214, 3, 1, 0, 3, 1);
    tbl[17] = mk(0, 1, 32'h40,  1, 1, 1,  1, 1, 1, 32'h10,  0, 1, 0, 3, 2);
    tbl[18] = mk(0, 0, 32'h0,   0, 0, 0,  0, 1, 0, 32'h10,  0, 1, 0, 3, 2);
    tbl[19] = mk(0, 1, 32'h50,  0, 1, 0,  0, 1, 0, 32'h10,  1, 1, 1, 3, 2);
    tbl[20] = mk(0, 0, 32'h0,   0, 1, 0,  1, 0, 0, 32'h10,  0, 1, 1, 3, 2);
    tbl[21] = mk(0, 1, 32'h60,  1, 0, 0,  0, 0, 0, 32'h10,  1, 1, 1, 3, 2);
    tbl[22] = mk(0, 1, 32'h64,  1, 0, 0,  0, 0, 0, 32'h10,  2, 1, 1, 3, 2);
    tbl[23] = mk(0, 1, 32'h68,  0, 0, 0,  0, 0, 0, 32'h10,  3, 1, 1, 3, 2);
    tbl[24] = mk(1, 1, 32'h70,  1, 1, 1,  0, 0, 0, 32'h0,   0, 0, 0, 0, 0);
    tbl[25] = mk(0, 0, 32'h0,   0, 1, 1,  0, 0, 0, 32'h0,   0, 0, 1, 0, 0);
    tbl[26] = mk(1, 0, 32'h0,   0, 0, 0,  0, 0, 0, 32'h0,   0, 0, 0, 0, 0);

    for (int i = 0; i < 27; i++)
      step(tbl[i].r, tbl[i].p, tbl[i].pc, tbl[i].pr, tbl[i].res, tbl[i].tk, tbl[i].e);

    // Reference model takes over from the reset state left by the last table row.
    model_reset();
    for (int i = 0; i < 12; i++) begin
      bit pr, tk;
      pr = i[0];
      tk = ((i - 1) % 2 == 1) ^ ((i == 6) || (i == 11));
      mstep(0, 1, 32'h1000 + 32'(i * 4), pr, (i > 0), tk);
    end
    mstep(0, 0, 32'h0, 0, 0, 0);

    for (int i = 0; i < 5; i++) begin
      mstep(0, 1, 32'h2000 + 32'(i * 4), 0, 0, 0);
      mstep(0, 0, 32'h0, 0, 1, 1);
    end

    for (int i = 0; i < 3; i++) mstep(0, 1, 32'h3000 + 32'(i * 4), 1, 0, 0);
    mstep(1, 1, 32'h3100, 1, 1, 0);
    mstep(0, 0, 32'h0, 0, 1, 1);
    mstep(0, 0, 32'h0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
